// File: rtl/t07_button_strobe.sv
// Six-key pushbutton front end: synchronizes, debounces and auto-repeats a
// one-hot key, emitting a registered key code plus a one-cycle event strobe.
module t07_button_strobe #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pb_raw,
  output logic [5:0] button,
  output logic       strobe
);

  localparam int MAX_C = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW    = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] REP_C = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HOLD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t          state_q;
  logic [5:0]      sync1_q;
  logic [5:0]      sync2_q;
  logic [5:0]      cand_q;
  logic [CW-1:0]   cnt_q;
  logic [5:0]      button_q;
  logic            strobe_q;
  logic            sync2_onehot;

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  assign sync2_onehot = is_onehot(sync2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 6'd0;
      sync2_q  <= 6'd0;
      cand_q   <= 6'd0;
      cnt_q    <= '0;
      button_q <= 6'd0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= pb_raw;
      sync2_q  <= sync1_q;
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_onehot) begin
            cand_q  <= sync2_q;
            cnt_q   <= ONE_C;
            state_q <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (sync2_q == cand_q) begin
            if (cnt_q == DEB_C) begin
              state_q  <= HOLD;
              strobe_q <= 1'b1;
              button_q <= cand_q;
              cnt_q    <= ONE_C;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end else if (sync2_onehot) begin
            cand_q <= sync2_q;
            cnt_q  <= ONE_C;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          // cnt doubles as the auto-repeat timer while the key stays down
          if (sync2_q == cand_q) begin
            if (REPEAT_CYCLES != 0) begin
              if (cnt_q == REP_C) begin
                strobe_q <= 1'b1;
                cnt_q    <= ONE_C;
              end else begin
                cnt_q <= cnt_q + ONE_C;
              end
            end
          end else begin
            state_q <= DEB_REL;
            cnt_q   <= (sync2_q == 6'd0) ? ONE_C : '0;
          end
        end
        DEB_REL: begin
          if (sync2_q == 6'd0) begin
            if (cnt_q == DEB_C) begin
              state_q  <= IDLE;
              button_q <= 6'd0;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end else if (sync2_q == cand_q) begin
            state_q <= HOLD;
            cnt_q   <= ONE_C;
          end else begin
            cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign button = button_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_t07_button_strobe.sv
// Bench for t07_button_strobe: two instances (no repeat / repeat 8) driven by
// shared stimulus, scored against a run-length reference model.
module tb_t07_button_strobe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] pb_raw = 6'd0;
  logic [5:0] btn0, btn1;
  logic       stb0, stb1;

  always #5 clk = ~clk;

  t07_button_strobe #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .pb_raw(pb_raw), .button(btn0), .strobe(stb0));
  t07_button_strobe #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut1 (
    .clk(clk), .rst(rst), .pb_raw(pb_raw), .button(btn1), .strobe(stb1));

  localparam int DEB [2] = '{4, 4};
  localparam int REP [2] = '{0, 8};

  typedef struct packed {
    logic       s0;
    logic [5:0] b0;
    logic       s1;
    logic [5:0] b1;
  } exp_t;

  exp_t expq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int stb_cnt0 = 0;
  int stb_cnt1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
  endtask

  function automatic bit onehot6(input logic [5:0] v);
    int n = 0;
    for (int b = 0; b < 6; b++) n += int'(v[b]);
    return n == 1;
  endfunction

  // Reference model: a key is accepted after D+1 identical one-hot samples,
  // released after D+1 zero samples; repeats every R samples while held.
  logic [5:0] m_s1 = 6'd0, m_s2 = 6'd0;
  int         ecount = 0;
  bit         held  [2] = '{0, 0};
  bit         relph [2] = '{0, 0};
  int         run   [2] = '{0, 0};
  int         zrun  [2] = '{0, 0};
  int         anchor[2] = '{0, 0};
  logic [5:0] cand  [2] = '{6'd0, 6'd0};

  initial forever begin
    logic [5:0] s;
    logic       st [2];
    exp_t       e;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_s1 = 6'd0; m_s2 = 6'd0; ecount = 0;
      for (int i = 0; i < 2; i++) begin
        held[i] = 0; relph[i] = 0; run[i] = 0; zrun[i] = 0; anchor[i] = 0; cand[i] = 6'd0;
      end
      expq.delete();
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = pb_raw; ecount++;
      for (int i = 0; i < 2; i++) begin
        st[i] = 1'b0;
        if (!held[i]) begin
          if (onehot6(s)) begin
            if (run[i] > 0 && s == cand[i]) run[i]++;
            else begin cand[i] = s; run[i] = 1; end
            if (run[i] == DEB[i] + 1) begin
              held[i] = 1; st[i] = 1'b1; anchor[i] = ecount; relph[i] = 0;
            end
          end else run[i] = 0;
        end else if (s == cand[i]) begin
          if (relph[i]) begin relph[i] = 0; anchor[i] = ecount; end
          else if (REP[i] > 0 && ecount - anchor[i] == REP[i]) begin
            st[i] = 1'b1; anchor[i] = ecount;
          end
        end else begin
          if (!relph[i]) begin relph[i] = 1; zrun[i] = 0; end
          if (s == 6'd0) zrun[i]++;
          else zrun[i] = 0;
          if (zrun[i] == DEB[i] + 1) begin held[i] = 0; run[i] = 0; relph[i] = 0; end
        end
      end
      e.s0 = st[0]; e.b0 = held[0] ? cand[0] : 6'd0;
      e.s1 = st[1]; e.b1 = held[1] ? cand[1] : 6'd0;
      expq.push_back(e);
    end
  end

  // Monitor: compares every cycle's outputs against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("rst_button0", 32'(btn0), 32'd0);
      chk("rst_strobe0", 32'(stb0), 32'd0);
      chk("rst_button1", 32'(btn1), 32'd0);
      chk("rst_strobe1", 32'(stb1), 32'd0);
    end else if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("strobe0", 32'(stb0), 32'(e.s0));
      chk("button0", 32'(btn0), 32'(e.b0));
      chk("strobe1", 32'(stb1), 32'(e.s1));
      chk("button1", 32'(btn1), 32'(e.b1));
      if (stb0 === 1'b1) stb_cnt0++;
      if (stb1 === 1'b1) stb_cnt1++;
    end
  end

  task automatic hold(input logic [5:0] v, input int n);
    pb_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    #1;
    stb_cnt0 = 0;
    stb_cnt1 = 0;
  endtask

  // Asynchronous reset pulse placed between edges, outputs checked at once.
  task automatic reset_pulse(input int n);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_button0", 32'(btn0), 32'd0);
    chk("async_rst_strobe0", 32'(stb0), 32'd0);
    chk("async_rst_button1", 32'(btn1), 32'd0);
    chk("async_rst_strobe1", 32'(stb1), 32'd0);
    repeat (n) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [5:0] one = 6'd1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Reset while a key is held, then idle with no strobes.
    hold(6'b000001, 12);
    chk("pre_rst_button0", 32'(btn0), 32'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_button0", 32'(btn0), 32'd0);
    chk("async_rst_strobe0", 32'(stb0), 32'd0);
    pb_raw = 6'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    clear_counts();
    hold(6'd0, 20);
    chk("idle_strobes0", 32'(stb_cnt0), 32'd0);
    chk("idle_strobes1", 32'(stb_cnt1), 32'd0);

    // RIGHT held 20 cycles.
    clear_counts();
    hold(6'b000100, 20);
    hold(6'd0, 12);
    chk("right_strobes0", 32'(stb_cnt0), 32'd1);
    chk("right_strobes1", 32'(stb_cnt1), 32'd2);

    // Short glitch.
    clear_counts();
    hold(6'b000010, 3);
    hold(6'd0, 12);
    chk("glitch_strobes0", 32'(stb_cnt0), 32'd0);
    chk("glitch_button0", 32'(btn0), 32'd0);

    // Multi-hot.
    clear_counts();
    hold(6'b000011, 20);
    hold(6'd0, 8);
    chk("multihot_strobes0", 32'(stb_cnt0), 32'd0);
    chk("multihot_strobes1", 32'(stb_cnt1), 32'd0);

    // DOWN held 30 cycles: auto-repeat on the second instance.
    clear_counts();
    hold(6'b001000, 30);
    hold(6'd0, 12);
    chk("repeat_strobes1", 32'(stb_cnt1), 32'd4);
    chk("repeat_strobes0", 32'(stb_cnt0), 32'd1);

    // Short dropout while held.
    clear_counts();
    hold(6'b010000, 15);
    hold(6'd0, 2);
    hold(6'b010000, 15);
    hold(6'd0, 12);
    chk("dropout_strobes0", 32'(stb_cnt0), 32'd1);

    // Key held through a reset pulse is pressed again afterwards.
    clear_counts();
    hold(6'b100000, 12);
    reset_pulse(2);
    hold(6'b100000, 12);
    hold(6'd0, 12);
    chk("held_thru_rst_strobes0", 32'(stb_cnt0), 32'd2);

    // Randomized segments.
    for (int k = 0; k < 250; k++) begin
      int         kind;
      logic [5:0] v;
      kind = $urandom_range(0, 19);
      if (kind < 8) begin
        v = one << $urandom_range(0, 5);
        hold(v, $urandom_range(1, 25));
      end else if (kind < 12) begin
        hold(6'd0, $urandom_range(1, 12));
      end else if (kind < 15) begin
        v = 6'($urandom) | 6'b000011;
        v = v << $urandom_range(0, 4);
        if (onehot6(v) || v == 6'd0) v = 6'b110000;
        hold(v, $urandom_range(1, 10));
      end else if (kind < 19) begin
        v = one << $urandom_range(0, 5);
        hold(v, $urandom_range(1, 4));
      end else begin
        reset_pulse($urandom_range(1, 3));
      end
    end
    hold(6'd0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
